// File: rtl/vga_sync_gen_if.sv
// Video-side bundle for vga_sync_gen: pixel position, colour in/out, syncs and frame marker.
interface vga_sync_gen_if;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic [5:0] rgb_in;
  logic [5:0] rgb_out;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output col, row, valid, rgb_out, hsync, vsync, frame_start,
    input  rgb_in
  );

  modport slave (
    input  col, row, valid, rgb_out, hsync, vsync, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator with registered colour and sync outputs.
// Define VGA_PIXEL_DIV2_EN to tick pixels on every second clk (50 MHz input clock).
module vga_sync_gen (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vid
);
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  logic [9:0] col_r;
  logic [9:0] row_r;
  logic [9:0] col_next_s;
  logic [9:0] row_next_s;
  logic [5:0] rgb_r;
  logic [5:0] rgb_next_s;
  logic       hsync_r;
  logic       vsync_r;
  logic       frame_start_r;
  logic       started_r;
  logic       tick_s;
  logic       valid_s;
  logic       frame_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;

`ifdef VGA_PIXEL_DIV2_EN
  logic phase_r;

  // Divider toggle: cleared by reset so the first tick lands on the second cycle after release
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
    end
  end

  assign tick_s = phase_r;
`else
  assign tick_s = 1'b1;
`endif

  assign valid_s = (col_r < H_VISIBLE) && (row_r < V_VISIBLE);

  // Raster advance; the first tick after reset presents (0,0) as the frame start rather than stepping past it
  always_comb begin
    col_next_s   = col_r;
    row_next_s   = row_r;
    frame_next_s = 1'b0;
    if (!started_r) begin
      col_next_s   = 10'd0;
      row_next_s   = 10'd0;
      frame_next_s = 1'b1;
    end else if (col_r == H_LAST) begin
      col_next_s = 10'd0;
      if (row_r == V_LAST) begin
        row_next_s   = 10'd0;
        frame_next_s = 1'b1;
      end else begin
        row_next_s = row_r + 10'd1;
      end
    end else begin
      col_next_s = col_r + 10'd1;
    end
  end

  // Colour/sync stage decoded from the current position, registered one slot later
  always_comb begin
    rgb_next_s   = 6'b000000;
    hsync_next_s = 1'b1;
    vsync_next_s = 1'b1;
    if (started_r) begin
      rgb_next_s   = valid_s ? vid.rgb_in : 6'b000000;
      hsync_next_s = ~((col_r >= H_SYNC_START) && (col_r <= H_SYNC_END));
      vsync_next_s = ~((row_r >= V_SYNC_START) && (row_r <= V_SYNC_END));
    end else begin
      rgb_next_s = 6'b000000;
    end
  end

  // State and output registers; reset wins over a coincident tick, and non-tick cycles hold
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r         <= 10'd0;
      row_r         <= 10'd0;
      rgb_r         <= 6'b000000;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      frame_start_r <= 1'b0;
      started_r     <= 1'b0;
    end else if (tick_s) begin
      col_r         <= col_next_s;
      row_r         <= row_next_s;
      rgb_r         <= rgb_next_s;
      hsync_r       <= hsync_next_s;
      vsync_r       <= vsync_next_s;
      frame_start_r <= frame_next_s;
      started_r     <= 1'b1;
    end
  end

  assign vid.col         = col_r;
  assign vid.row         = row_r;
  assign vid.valid       = valid_s;
  assign vid.rgb_out     = rgb_r;
  assign vid.hsync       = hsync_r;
  assign vid.vsync       = vsync_r;
  assign vid.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen against a slot-index raster model.
module tb_vga_sync_gen;
`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif
  localparam int unsigned FRAME = 420000;
  localparam logic [29:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks;
  int passed;
  int unsigned n_slot;
  logic [5:0] rgb_prev;
  logic [29:0] obs;

  vga_sync_gen_if vid();

  vga_sync_gen dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  always #5 clk = ~clk;

  assign obs = {vid.col, vid.row, vid.valid, vid.rgb_out, vid.hsync, vid.vsync, vid.frame_start};

  // Expected outputs in slot n (n = 0 is the first slot after reset release); prev is the rgb_in of slot n-1.
  function automatic logic [29:0] model_vec(input int unsigned n, input logic [5:0] prev);
    int unsigned c, r, pc, pr;
    logic [5:0] e_rgb;
    logic e_hs, e_vs, e_fs, e_valid;
    c = n % 800;
    r = (n / 800) % 525;
    e_valid = (c < 640) && (r < 480);
    e_fs = ((n % FRAME) == 0);
    if (n == 0) begin
      e_rgb = 6'd0;
      e_hs = 1'b1;
      e_vs = 1'b1;
    end else begin
      pc = (n - 1) % 800;
      pr = ((n - 1) / 800) % 525;
      e_rgb = (pc < 640 && pr < 480) ? prev : 6'd0;
      e_hs = !(pc >= 656 && pc <= 751);
      e_vs = !(pr >= 490 && pr <= 491);
    end
    return {c[9:0], r[9:0], e_valid, e_rgb, e_hs, e_vs, e_fs};
  endfunction

  task automatic advance(input logic [5:0] rgb);
    vid.rgb_in = rgb;
    rgb_prev = rgb;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    n_slot++;
  endtask

  task automatic start_after_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    n_slot = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    vid.rgb_in = 6'b101010;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) $display("FAIL reset_hold: got %h want %h", obs, RESET_VEC);
    else passed++;
    reset = 1'b0;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    n_slot = 0;
    checks++;
    if (obs !== model_vec(0, rgb_prev)) $display("FAIL reset_first_slot: got %h want %h", obs, model_vec(0, rgb_prev));
    else passed++;
    for (int i = 0; i < 20; i++) begin
      advance(6'($urandom));
      checks++;
      if (obs !== model_vec(n_slot, rgb_prev))
        $display("FAIL reset_early_slot%0d: got %h want %h", n_slot, obs, model_vec(n_slot, rgb_prev));
      else passed++;
    end
  endtask

  task automatic test_line();
    int bad, hs_low, first_low, lit;
    bad = 0; hs_low = 0; first_low = -1; lit = 0;
    start_after_reset(2);
    for (int i = 0; i <= 1600; i++) begin
      if (obs !== model_vec(n_slot, rgb_prev)) begin
        bad++;
        if (bad <= 3) $display("  line diff slot %0d got %h want %h", n_slot, obs, model_vec(n_slot, rgb_prev));
      end
      if (n_slot >= 1 && n_slot <= 800) begin
        if (vid.hsync === 1'b0) begin
          hs_low++;
          if (first_low < 0) first_low = int'(n_slot);
        end
        if (vid.rgb_out === 6'b001100) lit++;
      end
      if (i < 1600) advance(6'b001100);
    end
    checks++;
    if (bad != 0) $display("FAIL line_model: got %0d bad slots want 0", bad);
    else passed++;
    checks++;
    if (hs_low != 96) $display("FAIL hsync_width: got %0d want 96", hs_low);
    else passed++;
    checks++;
    if (first_low != 657) $display("FAIL hsync_first_low: got slot %0d want 657", first_low);
    else passed++;
    checks++;
    if (lit != 640) $display("FAIL line_lit_slots: got %0d want 640", lit);
    else passed++;
  endtask

`ifdef VGA_PIXEL_DIV2_EN
  task automatic test_div2();
    logic [29:0] held;
    int bad, unstable;
    bad = 0; unstable = 0;
    start_after_reset(2);
    for (int i = 0; i <= 1600; i++) begin
      if (obs !== model_vec(n_slot, rgb_prev)) bad++;
      held = obs;
      vid.rgb_in = 6'($urandom);
      rgb_prev = vid.rgb_in;
      @(posedge clk);
      @(negedge clk);
      if (obs !== held) unstable++;
      @(posedge clk);
      @(negedge clk);
      n_slot++;
    end
    checks++;
    if (bad != 0) $display("FAIL div2_model: got %0d bad slots want 0", bad);
    else passed++;
    checks++;
    if (unstable != 0) $display("FAIL div2_hold: got %0d changes on non-tick cycles want 0", unstable);
    else passed++;
  endtask
`endif

  task automatic test_midframe_reset();
    int bad;
    int unsigned target;
    bad = 0;
    target = 200 * 800 + 300;
    start_after_reset(1);
    for (int unsigned i = 0; i < target; i++) begin
      if (obs !== model_vec(n_slot, rgb_prev)) bad++;
      advance(6'($urandom));
    end
    checks++;
    if (bad != 0) $display("FAIL midframe_model: got %0d bad slots want 0", bad);
    else passed++;
    checks++;
    if ({vid.col, vid.row} !== {10'd300, 10'd200})
      $display("FAIL midframe_position: got col %0d row %0d want col 300 row 200", vid.col, vid.row);
    else passed++;
    reset = 1'b1;
    vid.rgb_in = 6'h3F;
    @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) $display("FAIL midframe_reset_state: got %h want %h", obs, RESET_VEC);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    n_slot = 0;
    checks++;
    if (obs !== model_vec(0, rgb_prev)) $display("FAIL midframe_restart: got %h want %h", obs, model_vec(0, rgb_prev));
    else passed++;
    for (int i = 0; i < 5; i++) begin
      advance(6'($urandom));
      checks++;
      if (obs !== model_vec(n_slot, rgb_prev))
        $display("FAIL midframe_after_slot%0d: got %h want %h", n_slot, obs, model_vec(n_slot, rgb_prev));
      else passed++;
    end
  endtask

  task automatic test_frame();
    int bad, vs_low, fs_cnt, vb_bad;
    int unsigned pr;
    logic [19:0] last_cr, wrap_cr;
    logic wrap_fs;
    bad = 0; vs_low = 0; fs_cnt = 0; vb_bad = 0;
    last_cr = 20'd0; wrap_cr = 20'hFFFFF; wrap_fs = 1'b0;
    start_after_reset(3);
    for (int unsigned i = 0; i <= FRAME + 800; i++) begin
      if (obs !== model_vec(n_slot, rgb_prev)) begin
        bad++;
        if (bad <= 3) $display("  frame diff slot %0d got %h want %h", n_slot, obs, model_vec(n_slot, rgb_prev));
      end
      if (n_slot >= 1 && n_slot <= FRAME && vid.vsync === 1'b0) vs_low++;
      if (n_slot < FRAME && vid.frame_start === 1'b1) fs_cnt++;
      if (n_slot == FRAME - 1) last_cr = {vid.col, vid.row};
      if (n_slot == FRAME) begin
        wrap_cr = {vid.col, vid.row};
        wrap_fs = vid.frame_start;
      end
      if (n_slot >= 1) begin
        pr = ((n_slot - 1) / 800) % 525;
        if (pr >= 480 && vid.rgb_out !== 6'd0) vb_bad++;
      end
      if (i < FRAME + 800) advance((((n_slot / 800) % 525) >= 480) ? 6'h3F : 6'($urandom));
    end
    checks++;
    if (bad != 0) $display("FAIL frame_model: got %0d bad slots want 0", bad);
    else passed++;
    checks++;
    if (vs_low != 1600) $display("FAIL vsync_width: got %0d want 1600", vs_low);
    else passed++;
    checks++;
    if (fs_cnt != 1) $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
    else passed++;
    checks++;
    if (last_cr !== {10'd799, 10'd524}) $display("FAIL frame_last_pos: got %h want %h", last_cr, {10'd799, 10'd524});
    else passed++;
    checks++;
    if ({wrap_cr, wrap_fs} !== {20'd0, 1'b1}) $display("FAIL frame_wrap: got %h want %h", {wrap_cr, wrap_fs}, {20'd0, 1'b1});
    else passed++;
    checks++;
    if (vb_bad != 0) $display("FAIL vblank_black: got %0d lit slots want 0", vb_bad);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    n_slot = 0;
    rgb_prev = 6'd0;
    vid.rgb_in = 6'd0;
    test_reset();
    test_line();
`ifdef VGA_PIXEL_DIV2_EN
    test_div2();
`endif
    test_midframe_reset();
    test_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
